// File: rtl/multicycle_core.sv
// Multi-cycle RV-style integer core (add/sub/and/or/addi/ld/sd/beq/halt); define BRANCH_EXT_EN to add bne/blt.
// Latency 3-5 cycles per instruction plus memory wait states; imem_ready/dmem_ready stall FETCH/MEM in place.
module multicycle_core #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted
);

  localparam logic [2:0] LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q, alu_q, ld_q;
  logic            armed;
  logic [XLEN-1:0] rf [32];

  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1a, rs2a;
  logic [2:0]      funct3;
  logic            is_r, is_addi, is_load, is_store, is_br, is_halt, legal, br_f3_ok;
  logic [XLEN-1:0] imm_dec, alu_res, wb_val;
  logic            br_take;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1a   = ir[19:15];
  assign rs2a   = ir[24:20];
  assign funct7 = ir[31:25];

`ifdef BRANCH_EXT_EN
  assign br_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100);
`else
  assign br_f3_ok = (funct3 == 3'b000);
`endif

  assign is_r     = (opcode == 7'b0110011) &&
                    (((funct7 == 7'h00) && ((funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111))) ||
                     ((funct7 == 7'h20) && (funct3 == 3'b000)));
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_load  = (opcode == 7'b0000011) && (funct3 == LS_F3);
  assign is_store = (opcode == 7'b0100011) && (funct3 == LS_F3);
  assign is_br    = (opcode == 7'b1100011) && br_f3_ok;
  assign is_halt  = (opcode == 7'b1111111);
  assign legal    = is_r || is_addi || is_load || is_store || is_br || is_halt;

  always_comb begin
    imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
    if (opcode == 7'b0100011) begin
      imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    end else if (opcode == 7'b1100011) begin
      imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    end
  end

  always_comb begin
    alu_res = rs1_q + imm_q;
    if (is_r) begin
      case (funct3)
        3'b111:  alu_res = rs1_q & rs2_q;
        3'b110:  alu_res = rs1_q | rs2_q;
        default: alu_res = funct7[5] ? (rs1_q - rs2_q) : (rs1_q + rs2_q);
      endcase
    end
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = (rs1_q == rs2_q);
`ifdef BRANCH_EXT_EN
      3'b001:  br_take = (rs1_q != rs2_q);
      3'b100:  br_take = ($signed(rs1_q) < $signed(rs2_q));
`endif
      default: br_take = 1'b0;
    endcase
  end

  assign wb_val = is_load ? ld_q : alu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH: begin
        imem_req = armed;
        if (armed && imem_ready) state_n = DECODE;
      end
      DECODE: state_n = legal ? EXEC : HALT;
      EXEC: begin
        if (is_br) begin
          state_n = FETCH;
          retire  = 1'b1;
        end else if (is_load || is_store) begin
          state_n = MEM;
        end else if (is_halt) begin
          state_n = HALT;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          state_n = is_load ? WB : FETCH;
          retire  = !is_load;
        end
      end
      WB: begin
        state_n = FETCH;
        retire  = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: state_n = FETCH;
    endcase
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = rs2_q;
  assign pc         = pc_q;

  // armed holds off the first fetch request until one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir    <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      alu_q <= '0;
      ld_q  <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        FETCH:  if (armed && imem_ready) ir <= imem_rdata;
        DECODE: begin
          rs1_q <= rf[rs1a];
          rs2_q <= rf[rs2a];
          imm_q <= imm_dec;
        end
        EXEC: begin
          alu_q <= alu_res;
          if (is_br) pc_q <= br_take ? (pc_q + imm_q) : (pc_q + XLEN'(4));
        end
        MEM: begin
          if (dmem_ready) begin
            if (is_load) ld_q <= dmem_rdata;
            else         pc_q <= pc_q + XLEN'(4);
          end
        end
        WB:      pc_q <= pc_q + XLEN'(4);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if ((state == WB) && (rd != 5'd0)) begin
      rf[rd] <= wb_val;
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: ISA-level reference model, memory responders with programmable wait states.
module tb_multicycle_core;
  localparam int XLEN = 64;
  localparam logic [31:0] HALT_I = 32'h0000007f;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [XLEN-1:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [31:0]     imem_rdata;

  multicycle_core #(.XLEN(XLEN), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] prog [64];
  int np;
  logic [63:0] mem_dut [64];
  logic [63:0] mem_ref [64];
  int idel, ddel, stab_err, both_err;
  int cyc, t0;
  bit started, pend;
  logic [63:0] got_t[$], got_pc[$], got_sa[$], got_sd[$];
  logic [63:0] exp_t[$], exp_pc[$], exp_sa[$], exp_sd[$];
  logic [63:0] exp_pc_final;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fetch(input logic [63:0] a);
    if (a < 64'd256) return prog[a[7:2]];
    return HALT_I;
  endfunction

  function automatic logic [31:0] r_ins(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    logic [6:0] a = f7[6:0];
    logic [2:0] b = f3[2:0];
    return {a, rs2[4:0], rs1[4:0], b, rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int f3, input int rd, input int rs1, input int imm);
    logic [11:0] v = imm[11:0];
    return {v, rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] s_ins(input int rs2, input int rs1, input int imm);
    logic [11:0] v = imm[11:0];
    return {v[11:5], rs2[4:0], rs1[4:0], 3'b011, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_ins(input int f3, input int rs1, input int rs2, input int imm);
    logic [12:0] v = imm[12:0];
    return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:1], v[11], 7'b1100011};
  endfunction

  task automatic clr();
    for (int i = 0; i < 64; i++) prog[i] = HALT_I;
    np = 0;
  endtask

  task automatic emit(input logic [31:0] ins);
    prog[np] = ins;
    np++;
  endtask

  // Architectural model: executes the program instruction by instruction and predicts
  // the retire cycle stamps, post-retire pc values and store stream.
  task automatic model_run(input int di, input int dd);
    logic [63:0] r [32];
    logic [63:0] p, a, b, res, nxt, ii, is, ib;
    logic [31:0] ins;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int t, extra;
    bit done, ill, wr, take;
    for (int i = 0; i < 32; i++) r[i] = '0;
    p = '0; t = 0; done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      ins = fetch(p);
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      a = r[ins[19:15]]; b = r[ins[24:20]];
      ii = {{52{ins[31]}}, ins[31:20]};
      is = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      t += 3 + di;
      ill = 0; wr = 0; res = '0; nxt = p + 64'd4; extra = 1;
      case (op)
        7'b0110011: begin
          wr = 1;
          if (f7 == 7'h00 && f3 == 3'd0)      res = a + b;
          else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
          else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
          else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
          else ill = 1;
        end
        7'b0010011: begin wr = 1; res = a + ii; ill = (f3 != 3'd0); end
        7'b0000011: begin
          wr = 1; ill = (f3 != 3'd3); extra = 2 + dd;
          res = mem_ref[(a + ii) >> 3 & 64'd63];
        end
        7'b0100011: begin
          ill = (f3 != 3'd3); extra = 1 + dd;
          if (!ill) begin
            mem_ref[(a + is) >> 3 & 64'd63] = b;
            exp_sa.push_back(a + is);
            exp_sd.push_back(b);
          end
        end
        7'b1100011: begin
          extra = 0; take = 0;
          if (f3 == 3'd0) take = (a == b);
`ifdef BRANCH_EXT_EN
          else if (f3 == 3'd1) take = (a != b);
          else if (f3 == 3'd4) take = ($signed(a) < $signed(b));
`endif
          else ill = 1;
          if (take) nxt = p + ib;
        end
        default: ill = 1;
      endcase
      if (ill || op == 7'h7f) begin
        done = 1;
        exp_pc_final = p;
      end else begin
        t += extra;
        if (wr && ins[11:7] != 5'd0) r[ins[11:7]] = res;
        p = nxt;
        exp_t.push_back(64'(t));
        exp_pc.push_back(p);
      end
    end
    if (!done) exp_pc_final = p;
  endtask

  initial begin : imem_resp
    int cnt;
    logic [63:0] a0;
    imem_ready = 1'b0; imem_rdata = '0; cnt = 0; a0 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !imem_req) begin
        imem_ready = 1'b0; cnt = 0;
      end else begin
        if (cnt == 0) a0 = imem_addr;
        else if (imem_addr !== a0) stab_err++;
        imem_ready = (cnt == idel);
        imem_rdata = (cnt == idel) ? fetch(imem_addr) : $urandom;
        cnt++;
      end
    end
  end

  initial begin : dmem_resp
    int cnt;
    logic [63:0] a0, w0;
    logic we0;
    dmem_ready = 1'b0; dmem_rdata = '0; cnt = 0; a0 = '0; w0 = '0; we0 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !dmem_req) begin
        dmem_ready = 1'b0; cnt = 0;
      end else begin
        if (cnt == 0) begin a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we; end
        else if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) stab_err++;
        dmem_ready = (cnt == ddel);
        dmem_rdata = {$urandom, $urandom};
        if (cnt == ddel) begin
          if (dmem_we) begin
            mem_dut[dmem_addr[8:3]] = dmem_wdata;
            got_sa.push_back(dmem_addr);
            got_sd.push_back(dmem_wdata);
          end else begin
            dmem_rdata = mem_dut[dmem_addr[8:3]];
          end
        end
        cnt++;
      end
    end
  end

  initial begin : monitor
    cyc = 0; t0 = 0; started = 0; pend = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        started = 0; pend = 0;
      end else begin
        if (!started && imem_req) begin started = 1; t0 = cyc; end
        if (imem_req && dmem_req) both_err++;
        if (pend) begin got_pc.push_back(pc); pend = 0; end
        if (retire) begin got_t.push_back(64'(cyc - t0 + 1)); pend = 1; end
      end
    end
  end

  task automatic run_test(input string tag, input int di, input int dd);
    int waited;
    logic [63:0] v, pc_hold;
    int nr;
    got_t.delete(); got_pc.delete(); got_sa.delete(); got_sd.delete();
    exp_t.delete(); exp_pc.delete(); exp_sa.delete(); exp_sd.delete();
    idel = di; ddel = dd; stab_err = 0; both_err = 0;
    for (int i = 0; i < 64; i++) begin
      v = {$urandom, $urandom};
      mem_dut[i] = v; mem_ref[i] = v;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({tag, ":rst_pc"}, pc, 64'd0);
    check({tag, ":rst_ireq"}, 64'(imem_req), 64'd0);
    check({tag, ":rst_dreq"}, 64'(dmem_req | dmem_we), 64'd0);
    check({tag, ":rst_halted"}, 64'(halted | retire), 64'd0);
    model_run(di, dd);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check({tag, ":first_fetch"}, 64'(imem_req), 64'd1);
    check({tag, ":first_addr"}, imem_addr, 64'd0);
    waited = 0;
    while (!halted && waited < 5000) begin
      @(negedge clk); #1; waited++;
    end
    check({tag, ":halt_reached"}, 64'(halted), 64'd1);
    pc_hold = pc;
    nr = got_t.size();
    repeat (4) @(negedge clk);
    #1;
    check({tag, ":halt_pc_frozen"}, pc, pc_hold);
    check({tag, ":halt_no_req"}, 64'(imem_req | dmem_req | retire), 64'd0);
    check({tag, ":halt_no_retire"}, 64'(got_t.size()), 64'(nr));
    check({tag, ":final_pc"}, pc, exp_pc_final);
    check({tag, ":retire_count"}, 64'(got_t.size()), 64'(exp_t.size()));
    for (int i = 0; i < exp_t.size() && i < got_t.size(); i++) begin
      check($sformatf("%s:retire_cycle[%0d]", tag, i), got_t[i], exp_t[i]);
      if (i < got_pc.size()) check($sformatf("%s:retire_pc[%0d]", tag, i), got_pc[i], exp_pc[i]);
    end
    check({tag, ":store_count"}, 64'(got_sa.size()), 64'(exp_sa.size()));
    for (int i = 0; i < exp_sa.size() && i < got_sa.size(); i++) begin
      check($sformatf("%s:store_addr[%0d]", tag, i), got_sa[i], exp_sa[i]);
      check($sformatf("%s:store_data[%0d]", tag, i), got_sd[i], exp_sd[i]);
    end
    check({tag, ":req_stable"}, 64'(stab_err), 64'd0);
    check({tag, ":req_exclusive"}, 64'(both_err), 64'd0);
  endtask

  task automatic gen_random();
    int sel, k;
    clr();
    for (int n = 0; n < 14; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: emit(i_ins(7'b0010011, 0, $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 4095)));
        1, 5: begin
          k = $urandom_range(0, 3);
          emit(r_ins((k == 1) ? 32 : 0, (k == 2) ? 7 : (k == 3) ? 6 : 0,
                     $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
        end
        2: emit(s_ins($urandom_range(0, 7), 0, 8 * $urandom_range(0, 31)));
        3: emit(i_ins(7'b0000011, 3, $urandom_range(1, 7), 0, 8 * $urandom_range(0, 31)));
        default: emit(b_ins(0, $urandom_range(0, 3), $urandom_range(0, 3), 8));
      endcase
    end
    for (int i = 1; i < 8; i++) emit(s_ins(i, 0, 8 * (32 + i)));
    emit(HALT_I);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int waited;
    // addi/addi/add then halt: three retires, pc stops at the halt.
    clr();
    emit(i_ins(7'b0010011, 0, 1, 0, 5));
    emit(i_ins(7'b0010011, 0, 2, 0, -3));
    emit(r_ins(0, 0, 3, 1, 2));
    emit(HALT_I);
    run_test("arith", 0, 0);
    check("arith:retires", 64'(got_t.size()), 64'd3);
    check("arith:pc", pc, 64'd12);
    prog[3] = s_ins(3, 0, 0);
    prog[4] = HALT_I;
    run_test("arith_sd", 0, 0);
    if (got_sd.size() > 0) check("arith_sd:x3", got_sd[0], 64'd2);
    else check("arith_sd:x3_seen", 64'd0, 64'd1);

    // Build 0xDEAD, store then reload through a slow data memory.
    clr();
    emit(i_ins(7'b0010011, 0, 1, 0, 32'h6f));
    for (int i = 0; i < 9; i++) emit(r_ins(0, 0, 1, 1, 1));
    emit(i_ins(7'b0010011, 0, 1, 1, 32'had));
    emit(s_ins(1, 0, 8));
    emit(i_ins(7'b0000011, 3, 4, 0, 8));
    emit(s_ins(4, 0, 16));
    emit(HALT_I);
    run_test("ldst_slow", 0, 3);
    if (got_t.size() >= 14 && got_sd.size() >= 2) begin
      check("ldst_slow:store_addr", got_sa[0], 64'd8);
      check("ldst_slow:sd_data", got_sd[0], 64'hdead);
      check("ldst_slow:x4", got_sd[1], 64'hdead);
      check("ldst_slow:store_cycles", got_t[11] - got_t[10], 64'd7);
      check("ldst_slow:load_cycles", got_t[12] - got_t[11], 64'd8);
    end else check("ldst_slow:enough_events", 64'(got_t.size()), 64'd14);
    run_test("ldst_wait", 2, 1);

    // Branch loop: beq at 16 jumps back to 8 once, then exits to 20.
    clr();
    emit(i_ins(7'b0010011, 0, 1, 0, 2));
    emit(b_ins(0, 1, 0, 8));
    emit(i_ins(7'b0010011, 0, 3, 3, 1));
    emit(b_ins(0, 3, 1, 8));
    emit(b_ins(0, 0, 0, -8));
    emit(HALT_I);
    run_test("branch", 0, 0);
    if (got_pc.size() == 7) begin
      check("branch:nt_pc", got_pc[1], 64'd8);
      check("branch:back_pc", got_pc[4], 64'd8);
      check("branch:beq_cycles", got_t[4] - got_t[3], 64'd3);
      check("branch:exit_pc", got_pc[6], 64'd20);
    end else check("branch:retires", 64'(got_pc.size()), 64'd7);

    // x0 is never written.
    clr();
    emit(i_ins(7'b0010011, 0, 0, 0, 7));
    emit(r_ins(0, 0, 5, 0, 0));
    emit(s_ins(5, 0, 0));
    emit(HALT_I);
    run_test("x0", 0, 0);
    if (got_sd.size() > 0) check("x0:x5", got_sd[0], 64'd0);
    else check("x0:store_seen", 64'd0, 64'd1);

    // bne / blt: supported only with the branch extension.
    clr();
    emit(i_ins(7'b0010011, 0, 1, 0, 1));
    emit(b_ins(1, 1, 2, 8));
    emit(HALT_I);
    emit(i_ins(7'b0010011, 0, 1, 0, -1));
    emit(b_ins(4, 1, 0, 8));
    emit(HALT_I);
    run_test("bext", 0, 0);
`ifdef BRANCH_EXT_EN
    check("bext:pc", pc, 64'd24);
`else
    check("bext:pc", pc, 64'd4);
    check("bext:retires", 64'(got_t.size()), 64'd1);
`endif

    // Unsupported encodings halt at decode with no retire.
    clr();
    emit(r_ins(1, 0, 1, 0, 0));
    run_test("bad_funct7", 1, 0);
    check("bad_funct7:retires", 64'(got_t.size()), 64'd0);
    clr();
    emit(i_ins(7'b0010011, 0, 1, 0, 9));
    emit(i_ins(7'b0000011, 2, 2, 0, 0));
    emit(s_ins(1, 0, 0));
    run_test("bad_width", 0, 0);
    check("bad_width:pc", pc, 64'd4);

    // Reset in the middle of a data access.
    clr();
    emit(i_ins(7'b0000011, 3, 1, 0, 16));
    emit(HALT_I);
    idel = 0; ddel = 40;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waited = 0;
    while (!dmem_req && waited < 50) begin @(negedge clk); #1; waited++; end
    check("rst_mid:dreq_seen", 64'(dmem_req), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid:dreq_drop", 64'(dmem_req | dmem_we), 64'd0);
    check("rst_mid:pc", pc, 64'd0);
    check("rst_mid:outs", 64'(imem_req | retire | halted), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid:refetch", 64'(imem_req), 64'd1);
    check("rst_mid:refetch_addr", imem_addr, 64'd0);
    run_test("rst_mid_rerun", 0, 0);

    for (int r = 0; r < 6; r++) begin
      gen_random();
      run_test($sformatf("rand%0d", r), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
